// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: fetches into IR, sequences
// FETCH/DECODE/EXEC/MEM/WB, decodes datapath strobes, counts retires, traps faults.
module control_fsm #(
    parameter int FETCH_WAIT_MAX = 255,
    parameter int COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               proc_rst,
    input  logic [15:0]        instr_in,
    input  logic               instr_valid,
    input  logic               Carry,
    input  logic               Zero,
    input  logic               alu_zero,
    output logic               fetch_req,
    output logic [15:0]        instruction,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               alu_src,
    output logic               pc_write,
    output logic               pc_src,
    output logic [2:0]         alu_op,
    output logic [2:0]         state,
    output logic               illegal,
    output logic               timeout,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int WAIT_W = (FETCH_WAIT_MAX > 1) ? $clog2(FETCH_WAIT_MAX + 1) : 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b111
    } state_t;

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;

    logic [3:0] op;
    logic [1:0] cz;
    logic       is_rtype;
    logic       legal;
    logic       r_cond;

    assign state = st;
    assign op    = instruction[15:12];
    assign cz    = instruction[1:0];

    assign is_rtype = (op == OP_ADD) || (op == OP_NAND);
    assign legal    = (is_rtype && (cz != 2'b11)) || (op == OP_ADI) || (op == OP_LW) ||
                      (op == OP_SW) || (op == OP_BEQ) || (op == OP_HLT);

    // Conditional write for R-type, using the flags as they stand during WB
    always_comb begin
        r_cond = 1'b0;
        case (cz)
            2'b00:   r_cond = 1'b1;
            2'b10:   r_cond = Carry;
            2'b01:   r_cond = Zero;
            default: r_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            st          <= S_FETCH;
            instruction <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (instr_valid) begin
                        instruction <= instr_in;
                        wait_cnt    <= '0;
                        st          <= S_DECODE;
                    end else if (FETCH_WAIT_MAX != 0) begin
                        // Trap on the cycle that would bring the count up to the limit
                        if (wait_cnt == WAIT_W'(FETCH_WAIT_MAX - 1)) begin
                            timeout  <= 1'b1;
                            wait_cnt <= '0;
                            st       <= S_HALT;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        illegal <= 1'b1;
                        st      <= S_HALT;
                    end else if (op == OP_HLT) begin
                        st <= S_HALT;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_LW, OP_SW: st <= S_MEM;
                        OP_BEQ: begin
                            instr_count <= instr_count + COUNT_W'(1);
                            st          <= S_FETCH;
                        end
                        default: st <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (op == OP_LW) begin
                        st <= S_WB;
                    end else begin
                        instr_count <= instr_count + COUNT_W'(1);
                        st          <= S_FETCH;
                    end
                end
                S_WB: begin
                    instr_count <= instr_count + COUNT_W'(1);
                    st          <= S_FETCH;
                end
                S_HALT: st <= S_HALT;
                default: st <= S_HALT;
            endcase
        end
    end

    // Strobes decode from registered state/IR; everything is forced low while in reset
    always_comb begin
        fetch_req = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        alu_op    = ALU_ADD;
        if (proc_rst) begin
            case (st)
                S_FETCH: begin
                    fetch_req = 1'b1;
                    ir_write  = instr_valid;
                end
                S_DECODE: begin
                    pc_write = legal && (op != OP_HLT);
                end
                S_EXEC: begin
                    case (op)
                        OP_NAND: alu_op = ALU_NAND;
                        OP_ADI, OP_LW, OP_SW: alu_src = 1'b1;
                        OP_BEQ: begin
                            alu_op   = ALU_SUB;
                            pc_write = alu_zero;
                            pc_src   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    alu_src   = 1'b1;
                    mem_read  = (op == OP_LW);
                    mem_write = (op == OP_SW);
                end
                S_WB: begin
                    case (op)
                        OP_ADD:  reg_write = r_cond;
                        OP_NAND: begin
                            reg_write = r_cond;
                            alu_op    = ALU_NAND;
                        end
                        OP_ADI, OP_LW: begin
                            reg_write = 1'b1;
                            alu_src   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboarded directed bench for control_fsm: stimulus queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_control_fsm;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd7;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic [15:0] instr_in;
    logic        instr_valid, Carry, Zero, alu_zero;
    logic        fetch_req, ir_write, reg_write, mem_read, mem_write, alu_src, pc_write, pc_src;
    logic [15:0] instruction;
    logic [2:0]  alu_op, state;
    logic        illegal, timeout;
    logic [3:0]  instr_count;

    control_fsm #(.FETCH_WAIT_MAX(4), .COUNT_W(4)) dut (
        .clk(clk), .proc_rst(proc_rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .Carry(Carry), .Zero(Zero), .alu_zero(alu_zero), .fetch_req(fetch_req),
        .instruction(instruction), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .pc_write(pc_write),
        .pc_src(pc_src), .alu_op(alu_op), .state(state), .illegal(illegal),
        .timeout(timeout), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // stb = {fetch_req, ir_write, reg_write, mem_read, mem_write, alu_src, pc_write, pc_src}
    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  stb;
        logic [2:0]  op;
        logic        ill;
        logic        to;
        logic [3:0]  cnt;
        logic [15:0] ir;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    logic [15:0] ir_m;
    logic [3:0]  cnt_m;
    logic        ill_m, to_m;

    always @(negedge clk) begin
        exp_t  e, g;
        string t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g = exp_t'{state, {fetch_req, ir_write, reg_write, mem_read, mem_write, alu_src, pc_write, pc_src},
                       alu_op, illegal, timeout, instr_count, instruction};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL %s: got st=%0d stb=%b op=%b ill=%b to=%b cnt=%0d ir=%h, want st=%0d stb=%b op=%b ill=%b to=%b cnt=%0d ir=%h",
                         t, g.st, g.stb, g.op, g.ill, g.to, g.cnt, g.ir,
                         e.st, e.stb, e.op, e.ill, e.to, e.cnt, e.ir);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic [7:0] stb, input logic [2:0] op);
        exp_q.push_back(exp_t'{st, stb, op, ill_m, to_m, cnt_m, ir_m});
        tag_q.push_back(tag);
    endtask

    task automatic row(input string tag, input logic [2:0] st, input logic [7:0] stb, input logic [2:0] op);
        push(tag, st, stb, op);
        tick();
    endtask

    task automatic fetch(input string tag, input logic [15:0] w);
        instr_in    = w;
        instr_valid = 1'b1;
        push({tag, "/fetch"}, S_F, 8'b1100_0000, 3'b000);
        tick();
        instr_valid = 1'b0;
        ir_m        = w;
    endtask

    task automatic do_reset(input string tag);
        proc_rst = 1'b0;
        ir_m = '0; cnt_m = '0; ill_m = 1'b0; to_m = 1'b0;
        row(tag, S_F, 8'b0000_0000, 3'b000);
        proc_rst = 1'b1;
    endtask

    task automatic alu(input string tag, input logic [15:0] w, input logic [2:0] e_op,
                       input logic e_as, input logic e_rw);
        fetch(tag, w);
        row({tag, "/dec"}, S_D, 8'b0000_0010, 3'b000);
        row({tag, "/exec"}, S_E, {5'b0, e_as, 2'b0}, e_op);
        row({tag, "/wb"}, S_W, {2'b0, e_rw, 2'b0, e_as, 2'b0}, e_op);
        cnt_m = cnt_m + 4'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        proc_rst = 1'b0; instr_in = '0; instr_valid = 1'b0;
        Carry = 1'b0; Zero = 1'b0; alu_zero = 1'b0;
        ir_m = '0; cnt_m = '0; ill_m = 1'b0; to_m = 1'b0;

        tick();
        do_reset("reset");

        alu("add", 16'h0298, 3'b000, 1'b0, 1'b1);
        Carry = 1'b0; alu("adc_c0", 16'h029A, 3'b000, 1'b0, 1'b0);
        Carry = 1'b1; alu("adc_c1", 16'h029A, 3'b000, 1'b0, 1'b1);
        Carry = 1'b0;
        Zero = 1'b1;  alu("adz_z1", 16'h0299, 3'b000, 1'b0, 1'b1);
        Zero = 1'b0;  alu("adz_z0", 16'h0299, 3'b000, 1'b0, 1'b0);
        alu("nand", 16'h2298, 3'b010, 1'b0, 1'b1);
        alu("adi", 16'h1283, 3'b000, 1'b1, 1'b1);

        fetch("lw", 16'hA283);
        row("lw/dec", S_D, 8'b0000_0010, 3'b000);
        row("lw/exec", S_E, 8'b0000_0100, 3'b000);
        row("lw/mem", S_M, 8'b0001_0100, 3'b000);
        row("lw/wb", S_W, 8'b0010_0100, 3'b000);
        cnt_m = cnt_m + 4'd1;

        fetch("sw", 16'hB283);
        row("sw/dec", S_D, 8'b0000_0010, 3'b000);
        row("sw/exec", S_E, 8'b0000_0100, 3'b000);
        row("sw/mem", S_M, 8'b0000_1100, 3'b000);
        cnt_m = cnt_m + 4'd1;

        alu_zero = 1'b1;
        fetch("beq_t", 16'hC283);
        row("beq_t/dec", S_D, 8'b0000_0010, 3'b000);
        row("beq_t/exec", S_E, 8'b0000_0011, 3'b001);
        cnt_m = cnt_m + 4'd1;
        alu_zero = 1'b0;
        fetch("beq_n", 16'hC283);
        row("beq_n/dec", S_D, 8'b0000_0010, 3'b000);
        row("beq_n/exec", S_E, 8'b0000_0001, 3'b001);
        cnt_m = cnt_m + 4'd1;

        // Undefined opcode: trap, then HALT must ignore fetch traffic
        fetch("op5", 16'h5000);
        row("op5/dec", S_D, 8'b0000_0000, 3'b000);
        ill_m = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr_valid = i[0];
            instr_in    = 16'($urandom);
            row("op5/halt", S_H, 8'b0000_0000, 3'b000);
        end
        instr_valid = 1'b0;
        #2;
        do_reset("rst_mid_cycle");

        fetch("cz11", 16'h029B);
        row("cz11/dec", S_D, 8'b0000_0000, 3'b000);
        ill_m = 1'b1;
        row("cz11/halt", S_H, 8'b0000_0000, 3'b000);
        do_reset("rst_cz11");

        alu("add2", 16'h0298, 3'b000, 1'b0, 1'b1);
        fetch("hlt", 16'hF000);
        row("hlt/dec", S_D, 8'b0000_0000, 3'b000);
        for (int i = 0; i < 3; i++) row("hlt/halt", S_H, 8'b0000_0000, 3'b000);
        do_reset("rst_hlt");

        // Reset arriving in the MEM cycle of a load must suppress mem_read at once
        fetch("lw_abort", 16'hA283);
        row("lw_abort/dec", S_D, 8'b0000_0010, 3'b000);
        row("lw_abort/exec", S_E, 8'b0000_0100, 3'b000);
        do_reset("rst_in_mem");

        // 4-bit counter: sixteen retires bring it back to zero
        for (int i = 0; i < 16; i++) alu("adi_wrap", 16'h1283, 3'b000, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) row("fetch_wait", S_F, 8'b1000_0000, 3'b000);
        to_m = 1'b1;
        row("timeout_halt", S_H, 8'b0000_0000, 3'b000);
        row("timeout_halt", S_H, 8'b0000_0000, 3'b000);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle control unit directly upstream of the 16-bit datapath. Fetches each instruction word through a valid handshake and holds it in an instruction register (IR).
- Sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable (reg_write, mem_read, mem_write, alu_src, pc_write, alu_op) from state plus IR.
- Also retires instructions and traps illegal opcodes and fetch timeouts.

Parameters:
- FETCH_WAIT_MAX, 255: max cycles in FETCH without instr_valid before timeout trap; 0 disables the timeout.
- COUNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- proc_rst  in  1  asynchronous, active-low reset
- instr_in  in  16  instruction word from instruction memory
- instr_valid  in  1  instr_in valid this cycle
- Carry  in  1  carry flag (from flag register)
- Zero  in  1  zero flag (from flag register)
- alu_zero  in  1  combinational ALU result==0, used by BEQ
- fetch_req  out  1  request an instruction word
- instruction  out  16  IR contents, fed to datapath
- ir_write  out  1  IR load strobe
- reg_write  out  1  register file write enable
- mem_read  out  1  data memory read
- mem_write  out  1  data memory write
- alu_src  out  1  1 selects zero-extended imm6 as ALU A
- pc_write  out  1  PC update enable
- pc_src  out  1  0 = PC+1, 1 = branch target
- alu_op  out  3  000 ADD, 001 SUB, 010 NAND
- state  out  3  FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, HALT 111
- illegal  out  1  sticky: undefined opcode trapped
- timeout  out  1  sticky: fetch timeout trapped
- instr_count  out  COUNT_W  retired instructions, wraps

Behaviour:
- Reset (proc_rst=0, async): state=FETCH, IR=0, instr_count=0, illegal=0, timeout=0, wait counter=0. All strobes 0 while reset is held. Reset mid-instruction abandons it with no partial writes after the reset edge.
- Strobes are Moore-decoded from registered state and IR. Unlisted strobes are 0. alu_op defaults to 000.
- Opcodes (IR[15:12]):
  - 0000 ADD and 0010 NAND are R-type; cz=IR[1:0]. 00 always writes; 10 writes only if Carry=1; 01 writes only if Zero=1; 11 is illegal.
  - 0001 ADI, 1010 LW, 1011 SW, 1100 BEQ, 1111 HLT.
  - All other opcodes are illegal.
- FETCH:
  - fetch_req=1. On instr_valid=1: ir_write=1 that cycle, IR<=instr_in at the edge, next state DECODE, wait counter cleared.
  - Otherwise the wait counter increments. When it reaches FETCH_WAIT_MAX (nonzero): timeout<=1, go to HALT.
- DECODE:
  - pc_write=1, pc_src=0 (PC+1) for every legal opcode.
  - Illegal opcode: no pc_write, illegal<=1, go to HALT.
  - HLT: go to HALT without illegal and without pc_write.
  - Otherwise go to EXEC.
- EXEC:
  - ADD/NAND: alu_src=0, alu_op=000 or 010, go to WB.
  - ADI: alu_src=1, alu_op=000, go to WB.
  - LW/SW: alu_src=1, alu_op=000 (imm6+Rb), go to MEM.
  - BEQ: alu_src=0, alu_op=001, pc_write=alu_zero, pc_src=1, go to FETCH (retire).
- MEM:
  - LW: mem_read=1, alu_src=1, alu_op=000, go to WB.
  - SW: mem_write=1, alu_src=1, alu_op=000, go to FETCH (retire).
- WB:
  - ALU ops: reg_write=cond, with alu_src/alu_op held as in EXEC. cond is evaluated on Carry/Zero sampled in WB.
  - LW: reg_write=1, alu_src=1.
  - Go to FETCH (retire).
- Retire: instr_count += 1 on every transition into FETCH from EXEC/MEM/WB. It wraps 2^COUNT_W-1 -> 0.
- HALT: absorbing; all strobes 0; only reset exits. HLT does not increment instr_count.
- Latency, counted from the instr_valid-accepted cycle to the retire edge:
  - ALU ops: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.

Test Plan:
- Reset, then present instr_in=0x0000+(ADD R1,R2,R3 =0x0298) with instr_valid=1 -> ir_write at cycle 0, pc_write/pc_src=0 in DECODE, reg_write=1 in WB, instr_count=1 after 4 cycles.
- ADC (cz=10) with Carry=0 -> reg_write=0 in WB, instr_count still increments. Repeat with Carry=1 -> reg_write=1.
- LW 0xA283 then SW 0xB283 -> mem_read=1 in MEM and reg_write=1 in WB for LW; mem_write=1 in MEM and no WB for SW; instr_count=2 after 9 cycles.
- BEQ 0xC...: alu_zero=1 -> pc_write=1, pc_src=1, alu_op=001 in EXEC. alu_zero=0 -> pc_write=0 in EXEC.
- Opcode 0x5 -> illegal=1, state=111, no pc_write. Hold there 20 cycles; toggle instr_valid -> no change. Drive proc_rst low mid-cycle -> immediate FETCH with flags cleared.
- FETCH_WAIT_MAX=4, instr_valid held 0 -> timeout=1 and HALT after 4 fetch cycles. With instr_count preset to 0xFFFF, one ADI retire -> 0x0000.
